// File: rtl/id_ex_pipe.sv
// ID/EX pipeline stage: valid/ready handshake, one-entry skid buffer, flush, and bubble masking.
// Optional stall/flush counters are enabled by defining ID_EX_PERF_EN.
module id_ex_pipe #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned WB_W = 2,
    parameter int unsigned M_W  = 3,
    parameter int unsigned EX_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WB_W-1:0] in_wb,
    input  logic [M_W-1:0]  in_m,
    input  logic [EX_W-1:0] in_ex,
    input  logic [DW-1:0]   in_pc,
    input  logic [DW-1:0]   in_rd1,
    input  logic [DW-1:0]   in_rd2,
    input  logic [DW-1:0]   in_se,
    input  logic [AW-1:0]   in_rs,
    input  logic [AW-1:0]   in_rt,
    output logic            out_valid,
    input  logic            out_ready,
`ifdef ID_EX_PERF_EN
    output logic [15:0]     stall_cnt,
    output logic [15:0]     flush_cnt,
`endif
    output logic [WB_W-1:0] out_wb,
    output logic [M_W-1:0]  out_m,
    output logic [EX_W-1:0] out_ex,
    output logic [DW-1:0]   out_pc,
    output logic [DW-1:0]   out_rd1,
    output logic [DW-1:0]   out_rd2,
    output logic [DW-1:0]   out_se,
    output logic [AW-1:0]   out_rs,
    output logic [AW-1:0]   out_rt
);

    localparam int unsigned PW = WB_W + M_W + EX_W + 4 * DW + 2 * AW;

    typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   main_q, main_d;
    logic [PW-1:0]   skid_q, skid_d;
    logic [PW-1:0]   in_payload;
    logic            accept, consume;
    logic [WB_W-1:0] wb_raw;
    logic [M_W-1:0]  m_raw;
    logic [EX_W-1:0] ex_raw;

    assign in_payload = {in_wb, in_m, in_ex, in_pc, in_rd1, in_rd2, in_se, in_rs, in_rt};
    assign out_valid  = (state_q != StEmpty);
    assign accept     = in_valid & in_ready;
    assign consume    = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StFull;
                    main_d  = in_payload;
                end
            end
            StFull: begin
                if (accept && consume) begin
                    main_d = in_payload;
                end else if (accept) begin
                    state_d = StSkid;
                    skid_d  = in_payload;
                end else if (consume) begin
                    state_d = StEmpty;
                end
            end
            StSkid: begin
                if (consume) begin
                    state_d = StFull;
                    main_d  = skid_q;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Payload may still load on flush; it is invisible because the state goes empty.
        if (flush) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StEmpty;
            in_ready <= 1'b1;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d != StSkid);
            main_q   <= main_d;
            skid_q   <= skid_d;
        end
    end

    assign {wb_raw, m_raw, ex_raw, out_pc, out_rd1, out_rd2, out_se, out_rs, out_rt} = main_q;

    // Bubbles carry zero control so execute needs no NOP decode.
    assign out_wb = wb_raw & {WB_W{out_valid}};
    assign out_m  = m_raw & {M_W{out_valid}};
    assign out_ex = ex_raw & {EX_W{out_valid}};

`ifdef ID_EX_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush && state_q != StEmpty && flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed self-checking bench for id_ex_pipe; perf counter checks apply when ID_EX_PERF_EN is defined.
module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_wb;
    logic [2:0]  in_m;
    logic [3:0]  in_ex;
    logic [31:0] in_pc, in_rd1, in_rd2, in_se;
    logic [4:0]  in_rs, in_rt;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_wb;
    logic [2:0]  out_m;
    logic [3:0]  out_ex;
    logic [31:0] out_pc, out_rd1, out_rd2, out_se;
    logic [4:0]  out_rs, out_rt;
`ifdef ID_EX_PERF_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    id_ex_pipe dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_wb    (in_wb),
        .in_m     (in_m),
        .in_ex    (in_ex),
        .in_pc    (in_pc),
        .in_rd1   (in_rd1),
        .in_rd2   (in_rd2),
        .in_se    (in_se),
        .in_rs    (in_rs),
        .in_rt    (in_rt),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef ID_EX_PERF_EN
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt),
`endif
        .out_wb   (out_wb),
        .out_m    (out_m),
        .out_ex   (out_ex),
        .out_pc   (out_pc),
        .out_rd1  (out_rd1),
        .out_rd2  (out_rd2),
        .out_se   (out_se),
        .out_rs   (out_rs),
        .out_rt   (out_rt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_wb = '0; in_m = '0; in_ex = '0; in_pc = '0; in_rd1 = '0; in_rd2 = '0;
        in_se = '0; in_rs = '0; in_rt = '0;
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_pc", out_pc, 0);
        chk("rst_ex", out_ex, 0);
        rst_n = 1'b1;

        // Single accept with full payload
        in_valid = 1'b1; out_ready = 1'b1;
        in_pc = 32'h40; in_ex = 4'b1010; in_wb = 2'b01; in_m = 3'b110;
        in_rd1 = 32'hDEAD_BEEF; in_rd2 = 32'h1234_5678; in_se = 32'hFFFF_FFF8;
        in_rs = 5'd17; in_rt = 5'd3;
        tick();
        in_valid = 1'b0;
        chk("single_valid", out_valid, 1);
        chk("single_pc", out_pc, 32'h40);
        chk("single_ex", out_ex, 4'b1010);
        chk("single_wb", out_wb, 2'b01);
        chk("single_m", out_m, 3'b110);
        chk("single_rd1", out_rd1, 32'hDEAD_BEEF);
        chk("single_rd2", out_rd2, 32'h1234_5678);
        chk("single_se", out_se, 32'hFFFF_FFF8);
        chk("single_rs", out_rs, 17);
        chk("single_rt", out_rt, 3);
        tick();
        chk("single_bubble_valid", out_valid, 0);
        chk("single_bubble_ex", out_ex, 0);
        chk("single_bubble_wb", out_wb, 0);

        // Back-pressure into skid
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h10;
        tick();
        chk("bp_pc0", out_pc, 32'h10);
        chk("bp_ready0", in_ready, 1);
        in_pc = 32'h14;
        tick();
        chk("bp_ready_skid", in_ready, 0);
        chk("bp_hold_pc", out_pc, 32'h10);
        in_pc = 32'h18;
        tick();
        chk("bp_hold_pc2", out_pc, 32'h10);
        chk("bp_hold_ready", in_ready, 0);
        out_ready = 1'b1;
        tick();
        chk("bp_out14", out_pc, 32'h14);
        chk("bp_ready_back", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_out18", out_pc, 32'h18);
        chk("bp_out18_valid", out_valid, 1);
        tick();
        chk("bp_drained", out_valid, 0);

        // Flush while skid holds an entry
        out_ready = 1'b0; in_valid = 1'b1;
        in_wb = 2'b11; in_m = 3'b111; in_ex = 4'hF; in_pc = 32'h20;
        tick();
        in_pc = 32'h24;
        tick();
        chk("fl_skid_ready", in_ready, 0);
        flush = 1'b1; in_pc = 32'h28;
        tick();
        chk("fl_valid", out_valid, 0);
        chk("fl_wb", out_wb, 0);
        chk("fl_m", out_m, 0);
        chk("fl_ex", out_ex, 0);
        chk("fl_ready", in_ready, 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("fl_no_emit", out_valid, 0);

        // Full throughput
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_pc = 32'h1000 + 32'(4 * i);
            tick();
            chk("tp_valid", out_valid, 1);
            chk("tp_pc", out_pc, 32'h1000 + 32'(4 * i));
            chk("tp_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("tp_drained", out_valid, 0);

        // Asynchronous reset while in skid
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h50;
        tick();
        in_pc = 32'h54;
        tick();
        in_valid = 1'b0;
        chk("ar_skid_ready", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_ready", in_ready, 1);
        chk("ar_pc", out_pc, 0);
        chk("ar_rd1", out_rd1, 0);
        chk("ar_rd2", out_rd2, 0);
        chk("ar_se", out_se, 0);
        chk("ar_rs", out_rs, 0);
        chk("ar_ex", out_ex, 0);
        tick();
        rst_n = 1'b1;

`ifdef ID_EX_PERF_EN
        chk("perf_rst_stall", stall_cnt, 0);
        chk("perf_rst_flush", flush_cnt, 0);
        in_valid = 1'b1; out_ready = 1'b0; in_pc = 32'h60;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("perf_stall5", stall_cnt, 5);
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0;
        chk("perf_flush1", flush_cnt, 1);
        chk("perf_stall_kept", stall_cnt, 5);
        tick();
        chk("perf_flush_empty", flush_cnt, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
